// File: rtl/mac_pkg.sv
// Shared types for the 2x2 matrix-multiply core and its stream loader.
package mac_pkg;
    localparam int MAC_DW = 16;
    localparam int MAC_RW = 32;

    typedef logic [MAC_DW-1:0] op_t;
    typedef logic [MAC_RW-1:0] res_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } loader_state_t;
endpackage

// File: rtl/matmult2x2.sv
// 2x2 unsigned matrix multiply, C = A x B, results wrap modulo 2^32.
// Latency: 3 register stages, so c is valid before the 4th edge after an operand update.
// Backpressure: none; free-running pipeline, operands must be held by the sequencer.
import mac_pkg::*;

module matmult2x2 (
    input  logic clk,
    input  logic rst,
    input  op_t  a00,
    input  op_t  a01,
    input  op_t  a10,
    input  op_t  a11,
    input  op_t  b00,
    input  op_t  b01,
    input  op_t  b10,
    input  op_t  b11,
    output res_t c00,
    output res_t c01,
    output res_t c10,
    output res_t c11
);
    res_t prod [4];
    res_t s1 [4];
    res_t s2 [4];
    res_t s3 [4];

    assign prod[0] = res_t'(a00) * res_t'(b00) + res_t'(a01) * res_t'(b10);
    assign prod[1] = res_t'(a00) * res_t'(b01) + res_t'(a01) * res_t'(b11);
    assign prod[2] = res_t'(a10) * res_t'(b00) + res_t'(a11) * res_t'(b10);
    assign prod[3] = res_t'(a10) * res_t'(b01) + res_t'(a11) * res_t'(b11);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                s1[i] <= '0;
                s2[i] <= '0;
                s3[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                s1[i] <= prod[i];
                s2[i] <= s1[i];
                s3[i] <= s2[i];
            end
        end
    end

    assign c00 = s3[0];
    assign c01 = s3[1];
    assign c10 = s3[2];
    assign c11 = s3[3];
endmodule

// File: rtl/matmult2x2_loader.sv
// Stream sequencer for matmult2x2: 8 operand words in, 4 result words out.
// Latency: results captured MAC_LATENCY edges after the 8th accept; 16 cycles/matrix at full rate.
// Backpressure: in_ready only in LOAD; out_data/out_last held while out_valid & !out_ready.
import mac_pkg::*;

module matmult2x2_loader #(
    parameter int DW          = MAC_DW,
    parameter int RW          = MAC_RW,
    parameter int MAC_LATENCY = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] a00,
    output logic [DW-1:0] a01,
    output logic [DW-1:0] a10,
    output logic [DW-1:0] a11,
    output logic [DW-1:0] b00,
    output logic [DW-1:0] b01,
    output logic [DW-1:0] b10,
    output logic [DW-1:0] b11,
    input  logic [RW-1:0] c00,
    input  logic [RW-1:0] c01,
    input  logic [RW-1:0] c10,
    input  logic [RW-1:0] c11,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);
    loader_state_t state, state_nxt;
    logic [2:0]    widx;
    logic [7:0]    wcnt;
    logic [1:0]    didx;
    logic [DW-1:0] ops [8];
    logic [RW-1:0] cap [4];
    logic          in_fire;
    logic          out_fire;
    logic          cap_en;

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DRAIN);
    assign busy      = (state != LOAD);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign cap_en    = (state == WAIT) && (wcnt == 8'd0);
    assign out_data  = out_valid ? cap[didx] : '0;
    assign out_last  = out_valid && (didx == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOAD;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (in_fire && widx == 3'd7)   state_nxt = WAIT;
            WAIT:    if (wcnt == 8'd0)              state_nxt = DRAIN;
            DRAIN:   if (out_fire && didx == 2'd3)  state_nxt = LOAD;
            default:                                state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            widx <= '0;
            wcnt <= '0;
            didx <= '0;
        end else begin
            if (in_fire) begin
                widx <= (widx == 3'd7) ? 3'd0 : widx + 3'd1;
                if (widx == 3'd7) wcnt <= 8'(MAC_LATENCY - 1);
            end
            if (state == WAIT && wcnt != 8'd0) wcnt <= wcnt - 8'd1;
            if (out_fire) didx <= didx + 2'd1;
        end
    end

    // Operands persist across matrices; only the addressed word is overwritten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) ops[i] <= '0;
        end else if (in_fire) begin
            ops[widx] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) cap[i] <= '0;
        end else if (cap_en) begin
            cap[0] <= c00;
            cap[1] <= c01;
            cap[2] <= c10;
            cap[3] <= c11;
        end
    end

    assign a00 = ops[0];
    assign a01 = ops[1];
    assign a10 = ops[2];
    assign a11 = ops[3];
    assign b00 = ops[4];
    assign b01 = ops[5];
    assign b10 = ops[6];
    assign b11 = ops[7];
endmodule
